div_seq: RTL
============

Name: div_seq

Overview:
Sequential signed restoring divider, the inverse datapath of the shift-add multiplier.
- Accepts two DW-bit two's-complement operands on a start pulse and iterates one quotient bit per clock.
- Applies sign correction, then holds quotient, remainder and status with a ready flag.
- Sits beside the multiplier in the switch/LED demo top and shares its start/ready handshake style.

Parameters:
DW, 8, operand, quotient and remainder width in bits (two's complement); minimum 2.

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-low
i_start  in  1  start request, sampled only in IDLE and DONE
i_dividend  in  DW  signed dividend
i_divisor  in  DW  signed divisor
o_quotient  out  DW  signed quotient, truncated toward zero
o_remainder  out  DW  signed remainder, same sign as dividend (or 0)
o_ready  out  1  result valid; level signal held while in DONE
o_busy  out  1  high in DIVIDE and SIGN
o_div_zero  out  1  divisor was 0 for the current result
o_ovf  out  1  quotient overflow (most-negative / -1)

Behaviour:
- Reset (i_rst=0 at a clock edge): state IDLE; all outputs 0; internal registers 0. Reset mid-operation aborts immediately with no partial result.
- States: IDLE, DIVIDE, SIGN, DONE.
- IDLE or DONE with i_start=1, at the edge:
  - Capture operand signs and unsigned magnitudes. Magnitudes are DW-bit unsigned, so the most-negative value maps to 2^(DW-1) without loss.
  - Clear accumulator A (DW+1 bits). Load Q with the dividend magnitude and M with the divisor magnitude. Set counter to DW. Clear o_ready and flags.
  - If divisor==0, go to DONE instead: o_quotient=0, o_remainder=i_dividend, o_div_zero=1, o_ready=1 on the next cycle.
  - Otherwise go to DIVIDE.
- DIVIDE, each cycle:
  - Shift {A,Q} left 1 and compute T = A_shifted - M.
  - If T >= 0: A=T, Q[0]=1. Else: A unchanged (shifted), Q[0]=0.
  - Decrement counter; after the DW-th iteration go to SIGN.
  - i_start is ignored.
- SIGN, one cycle:
  - Quotient is negated if the operand signs differ. Remainder is negated if the dividend was negative.
  - o_ovf=1 when the dividend is the most-negative value and the divisor is -1. o_quotient then equals the truncated value (most-negative); o_remainder=0.
  - Go to DONE.
- DONE: o_ready=1 and outputs held stable until the next accepted i_start or reset.
- Latency: accepted start edge to o_ready high = DW+2 cycles (10 for DW=8); div-by-zero = 1 cycle.
- Back-to-back: i_start in DONE restarts directly. o_ready drops the cycle after acceptance.
- o_busy=1 exactly in DIVIDE and SIGN.
- Zero dividend yields quotient 0 and remainder 0, never negative zero handling issues: negation of 0 stays 0.

Decomposition:
- Shared package (extend the existing multiplier package or add pkg_div):
  - state enum div_state_e {IDLE, DIVIDE, SIGN, DONE};
  - DW default constant;
  - struct div_t bundling internal wires (signs, magnitudes, A, Q, M, count).
- Reuse the existing two's-complement magnitude/sign converter for operand conditioning.
- One natural sub-module: div_shift_sub, the combinational shift/trial-subtract step producing next A, Q.
- Counter width: $clog2(DW+1).

Test Plan:
1. DW=8, 100 / 7 -> o_ready after 10 cycles; q=14, r=2; flags 0; o_busy high for cycles 1..9.
2. -100 / 7 -> q=-14 (0xF2), r=-2 (0xFE); 100 / -7 -> q=-14, r=2; -100 / -7 -> q=14, r=-2.
3. 55 / 0 -> o_ready next cycle, o_div_zero=1, q=0, r=55; then 9 / 3 -> q=3, r=0, o_div_zero cleared.
4. -128 / -1 -> o_ovf=1, q=-128 (0x80), r=0. Also -128 / 1 -> q=-128, r=0, o_ovf=0.
5. Start 100 / 7, drop i_rst at cycle 5 -> all outputs 0, state IDLE. Restart 3 / 5 -> q=0, r=3 after 10 cycles.
6. i_start held during DIVIDE -> ignored. i_start in DONE with 127 / 2 -> o_ready low next cycle, then q=63, r=1.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types for the sequential signed divider.
// State encoding, default width and the captured sign/overflow bundle.
package div_seq_pkg;

    localparam int DIV_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        SIGN,
        DONE
    } div_state_e;

    // Operand signs and the overflow case, captured at start and
    // consumed by the sign-correction cycle.
    typedef struct packed {
        logic dvd_neg;
        logic dvs_neg;
        logic ovf;
    } div_t;

endpackage

// File: rtl/div_seq_if.sv
// Start/ready handshake and result bus of the divider.
// master drives start and operands; slave returns results and status.
interface div_if #(
    parameter int DW = 8
);
    logic          i_start;
    logic [DW-1:0] i_dividend;
    logic [DW-1:0] i_divisor;
    logic [DW-1:0] o_quotient;
    logic [DW-1:0] o_remainder;
    logic          o_ready;
    logic          o_busy;
    logic          o_div_zero;
    logic          o_ovf;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_quotient, o_remainder, o_ready,
        input  o_busy, o_div_zero, o_ovf
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_quotient, o_remainder, o_ready,
        output o_busy, o_div_zero, o_ovf
    );
endinterface

// File: rtl/div_seq_shift_sub.sv
// One restoring-division step: shift {A,Q} left, trial-subtract M.
// Ports: a/q/m current state in, a_nxt/q_nxt next state out.
module div_shift_sub #(
    parameter int DW = 8
) (
    input  logic [DW:0]   a,
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] m,
    output logic [DW:0]   a_nxt,
    output logic [DW-1:0] q_nxt
);

    // One guard bit above A so the trial result sign is unambiguous.
    logic [DW+1:0] a_sh;
    logic [DW+1:0] t;

    assign a_sh = {a, q[DW-1]};
    assign t    = a_sh - {2'b00, m};

    always_comb begin
        a_nxt = a_sh[DW:0];
        q_nxt = {q[DW-2:0], 1'b0};
        if (!t[DW+1]) begin
            a_nxt = t[DW:0];
            q_nxt = {q[DW-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Ports: i_clk, i_rst (sync, active-low), bus (div_if slave).
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input logic  i_clk,
    input logic  i_rst,
    div_if.slave bus
);

    localparam int CW = $clog2(DW + 1);

    div_state_e    state_q;
    div_state_e    state_d;
    div_t          sgn_q;
    logic [DW:0]   a_q;
    logic [DW-1:0] q_q;
    logic [DW-1:0] m_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] rem_q;
    logic          dz_q;
    logic          ovf_q;

    logic [DW:0]   a_nxt;
    logic [DW-1:0] q_nxt;
    logic          accept;
    logic          dvs_zero;
    logic          ovf_in;
    logic [DW-1:0] dvd_mag;
    logic [DW-1:0] dvs_mag;

    // Magnitudes are unsigned DW bits, so the most-negative value
    // becomes 2^(DW-1) without loss.
    assign dvd_mag = bus.i_dividend[DW-1] ? -bus.i_dividend
                                          : bus.i_dividend;
    assign dvs_mag = bus.i_divisor[DW-1] ? -bus.i_divisor
                                         : bus.i_divisor;

    assign dvs_zero = (bus.i_divisor == '0);
    assign ovf_in   = (bus.i_dividend == {1'b1, {(DW-1){1'b0}}})
                   && (bus.i_divisor == '1);

    assign accept = bus.i_start
                 && ((state_q == IDLE) || (state_q == DONE));

    div_shift_sub #(
        .DW(DW)
    ) u_step (
        .a    (a_q),
        .q    (q_q),
        .m    (m_q),
        .a_nxt(a_nxt),
        .q_nxt(q_nxt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d = dvs_zero ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_q == CW'(1)) begin
                    state_d = SIGN;
                end
            end
            SIGN:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            sgn_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sgn_q.dvd_neg <= bus.i_dividend[DW-1];
                sgn_q.dvs_neg <= bus.i_divisor[DW-1];
                sgn_q.ovf     <= ovf_in;
                a_q           <= '0;
                q_q           <= dvd_mag;
                m_q           <= dvs_mag;
                cnt_q         <= CW'(DW);
                dz_q          <= dvs_zero;
                ovf_q         <= 1'b0;
                if (dvs_zero) begin
                    quo_q <= '0;
                    rem_q <= bus.i_dividend;
                end
            end else if (state_q == DIVIDE) begin
                a_q   <= a_nxt;
                q_q   <= q_nxt;
                cnt_q <= cnt_q - CW'(1);
            end else if (state_q == SIGN) begin
                // Remainder magnitude is below M, so A's low DW bits
                // hold it exactly; negating zero stays zero.
                quo_q <= (sgn_q.dvd_neg ^ sgn_q.dvs_neg) ? -q_q : q_q;
                rem_q <= sgn_q.dvd_neg ? -a_q[DW-1:0] : a_q[DW-1:0];
                ovf_q <= sgn_q.ovf;
            end
        end
    end

    assign bus.o_quotient  = quo_q;
    assign bus.o_remainder = rem_q;
    assign bus.o_ready     = (state_q == DONE);
    assign bus.o_busy      = (state_q == DIVIDE) || (state_q == SIGN);
    assign bus.o_div_zero  = dz_q;
    assign bus.o_ovf       = ovf_q;

endmodule
